// File: rtl/dqn_pkg.sv
// Shared constants and types for the DQN inference controller: Q-format, problem size, FSM states.
package dqn_pkg;
   localparam int DW         = 16;
   localparam int FRAC       = 10;
   localparam logic [DW-1:0] Q_ONE = 16'h0400;
   localparam int N_STATE    = 9;
   localparam int N_ACT      = 4;
   localparam int TIMEOUT    = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } infer_state_e;

   function automatic logic is_legal_state(input logic [3:0] s, input int n_state);
      return (s >= 4'd1) && (int'(s) <= n_state);
   endfunction
endpackage

// File: rtl/dqn_infer_ctrl_if.sv
// Request / network / result signals between the agent FSM, the encoder+datapath and the inference controller.
interface dqn_infer_ctrl_if #(
   parameter int DW    = 16,
   parameter int N_ACT = 4,
   parameter int AW    = $clog2(N_ACT)
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_state;
   logic [3:0]    st;
   logic          nn_start;
   logic          q_valid;
   logic [DW-1:0] q_data;
   logic          act_valid;
   logic          act_ready;
   logic [AW-1:0] action;
   logic [DW-1:0] q_max;
   logic          err;

   modport slave (
      input  req_valid, req_state, q_valid, q_data, act_ready,
      output req_ready, st, nn_start, act_valid, action, q_max, err
   );

   modport master (
      output req_valid, req_state, q_valid, q_data, act_ready,
      input  req_ready, st, nn_start, act_valid, action, q_max, err
   );
endinterface

// File: rtl/dqn_argmax_seq.sv
// Serial running-max over Q-value beats; beat index 0 always loads, later beats need a strictly larger value.
module dqn_argmax_seq #(
   parameter int DW    = 16,
   parameter int N_ACT = 4,
   parameter int IW    = $clog2(N_ACT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clr,
   input  logic                 i_beat,
   input  logic [IW-1:0]        i_idx,
   input  logic signed [DW-1:0] i_data,
   output logic signed [DW-1:0] o_best,
   output logic [IW-1:0]        o_idx
);
   logic signed [DW-1:0] r_best;
   logic [IW-1:0]        r_idx;
   logic                 w_take;

   // strict compare keeps the lowest index on ties
   assign w_take = i_beat && ((i_idx == '0) || (i_data > r_best));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best <= '0;
         r_idx  <= '0;
      end else if (i_clr) begin
         r_best <= '0;
         r_idx  <= '0;
      end else if (w_take) begin
         r_best <= i_data;
         r_idx  <= i_idx;
      end
   end

   assign o_best = r_best;
   assign o_idx  = r_idx;
endmodule

// File: rtl/dqn_infer_ctrl.sv
// Sequences one DQN inference: latch state, drive encoder, start datapath, argmax serial Q-values, return result.
// state | meaning
// IDLE  | ready for a request, st=0
// LOAD  | st driven with latched state, encoder settling
// WAIT  | nn_start pulsed, collecting Q beats, watchdog running
// RESP  | result (or err) presented until act_ready
module dqn_infer_ctrl
   import dqn_pkg::*;
#(
   parameter int P_N_STATE = N_STATE,
   parameter int P_N_ACT   = N_ACT,
   parameter int P_DW      = DW,
   parameter int P_TIMEOUT = TIMEOUT
) (
   input logic         clk,
   input logic         rst_n,
   dqn_infer_ctrl_if.slave bus
);
   localparam int IW = $clog2(P_N_ACT);
   localparam int TW = $clog2(P_TIMEOUT + 1);

   infer_state_e r_state, w_state_nxt;

   logic [3:0]       r_st;
   logic             r_nn_start;
   logic             r_err;
   logic [IW-1:0]    r_beat;
   logic [TW-1:0]    r_tmo;

   logic             w_accept;
   logic             w_legal;
   logic             w_beat;
   logic             w_last;
   logic             w_tmo;
   logic             w_clr;
   logic [P_DW-1:0]  w_best;
   logic [IW-1:0]    w_idx;

   assign w_legal  = is_legal_state(bus.req_state, P_N_STATE);
   assign w_accept = (r_state == IDLE) && bus.req_valid;
   assign w_beat   = (r_state == WAIT) && bus.q_valid;
   assign w_last   = w_beat && (r_beat == IW'(P_N_ACT - 1));
   assign w_tmo    = (r_state == WAIT) && !bus.q_valid && (r_tmo == '0);
   assign w_clr    = (r_state == LOAD);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (bus.req_valid) w_state_nxt = w_legal ? LOAD : RESP;
         LOAD: w_state_nxt = WAIT;
         WAIT: if (w_last || w_tmo) w_state_nxt = RESP;
         RESP: if (bus.act_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // watchdog is a down-counter reloaded on entry to WAIT and on every beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st       <= '0;
         r_nn_start <= 1'b0;
         r_err      <= 1'b0;
         r_beat     <= '0;
         r_tmo      <= '0;
      end else begin
         r_nn_start <= (r_state == LOAD);

         if (w_accept && w_legal)  r_st <= bus.req_state;
         else if (w_last || w_tmo) r_st <= '0;

         if (w_accept)   r_err <= !w_legal;
         else if (w_tmo) r_err <= 1'b1;

         if (r_state == LOAD) r_beat <= '0;
         else if (w_beat)     r_beat <= r_beat + 1'b1;

         if ((r_state == LOAD) || w_beat)         r_tmo <= TW'(P_TIMEOUT - 1);
         else if ((r_state == WAIT) && (r_tmo != '0)) r_tmo <= r_tmo - 1'b1;
      end
   end

   dqn_argmax_seq #(
      .DW    (P_DW),
      .N_ACT (P_N_ACT),
      .IW    (IW)
   ) u_argmax (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_beat (w_beat),
      .i_idx  (r_beat),
      .i_data (bus.q_data),
      .o_best (w_best),
      .o_idx  (w_idx)
   );

   assign bus.req_ready = (r_state == IDLE);
   assign bus.st        = r_st;
   assign bus.nn_start  = r_nn_start;
   assign bus.act_valid = (r_state == RESP);
   assign bus.err       = (r_state == RESP) && r_err;
   assign bus.action    = ((r_state == RESP) && !r_err) ? w_idx  : '0;
   assign bus.q_max     = ((r_state == RESP) && !r_err) ? w_best : '0;
endmodule

// File: tb/tb_dqn_infer_ctrl.sv
// Directed bench for dqn_infer_ctrl: legal runs, ties, illegal states, timeout, backpressure, reset mid-run.
module tb_dqn_infer_ctrl;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_start;
   int   n;

   dqn_infer_ctrl_if bus ();

   dqn_infer_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [3:0] s);
      bus.req_state = s;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      chk("load_st", 32'(bus.st), 32'(s));
      chk("load_ready", 32'(bus.req_ready), 32'd0);
      chk("load_nn_start", 32'(bus.nn_start), 32'd0);
   endtask

   task automatic do_beats(input logic [3:0] s, input logic [15:0] q [4],
                           input logic [1:0] ea, input logic [15:0] eq, input string tag);
      tick();
      chk({tag, "_nn_start"}, 32'(bus.nn_start), 32'd1);
      chk({tag, "_st_run"}, 32'(bus.st), 32'(s));
      n_start = 1;
      for (int i = 0; i < 4; i++) begin
         bus.q_valid = 1'b1;
         bus.q_data  = q[i];
         tick();
         if (bus.nn_start) n_start++;
         if (i < 3) chk({tag, "_st_hold"}, 32'(bus.st), 32'(s));
      end
      bus.q_valid = 1'b0;
      chk({tag, "_act_valid"}, 32'(bus.act_valid), 32'd1);
      chk({tag, "_err"}, 32'(bus.err), 32'd0);
      chk({tag, "_action"}, 32'(bus.action), 32'(ea));
      chk({tag, "_q_max"}, 32'(bus.q_max), 32'(eq));
      chk({tag, "_st_done"}, 32'(bus.st), 32'd0);
      chk({tag, "_start_pulses"}, 32'(n_start), 32'd1);
   endtask

   task automatic do_ack();
      bus.act_ready = 1'b1;
      tick();
      bus.act_ready = 1'b0;
      chk("ack_act_valid", 32'(bus.act_valid), 32'd0);
      chk("ack_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic do_illegal(input logic [3:0] s);
      bus.req_state = s;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      chk("ill_act_valid", 32'(bus.act_valid), 32'd1);
      chk("ill_err", 32'(bus.err), 32'd1);
      chk("ill_action", 32'(bus.action), 32'd0);
      chk("ill_q_max", 32'(bus.q_max), 32'd0);
      chk("ill_st", 32'(bus.st), 32'd0);
      chk("ill_nn_start", 32'(bus.nn_start), 32'd0);
      tick();
      chk("ill_nn_start2", 32'(bus.nn_start), 32'd0);
      do_ack();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_state = 4'd0;
      bus.q_valid   = 1'b0;
      bus.q_data    = 16'h0000;
      bus.act_ready = 1'b0;
      #3;
      chk("rst_st", 32'(bus.st), 32'd0);
      chk("rst_nn_start", 32'(bus.nn_start), 32'd0);
      chk("rst_act_valid", 32'(bus.act_valid), 32'd0);
      chk("rst_action", 32'(bus.action), 32'd0);
      chk("rst_q_max", 32'(bus.q_max), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      #9 rst_n = 1'b1;
      tick();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

      // stray beats while idle must be ignored
      bus.q_valid = 1'b1;
      bus.q_data  = 16'h7FFF;
      tick();
      tick();
      bus.q_valid = 1'b0;
      chk("idle_beats_act_valid", 32'(bus.act_valid), 32'd0);

      do_req(4'd5);
      do_beats(4'd5, '{16'h0100, 16'hFF00, 16'h0800, 16'h0400}, 2'd2, 16'h0800, "legal5");
      do_ack();

      do_req(4'd1);
      do_beats(4'd1, '{16'hFC00, 16'hFC00, 16'hF800, 16'hFC00}, 2'd0, 16'hFC00, "ties");
      do_ack();

      do_req(4'd9);
      do_beats(4'd9, '{16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF}, 2'd1, 16'h7FFF, "extremes");
      do_ack();

      do_req(4'd8);
      do_beats(4'd8, '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, 2'd3, 16'h0004, "ascend");
      do_ack();

      do_illegal(4'd0);
      do_illegal(4'd12);
      do_illegal(4'd10);

      // timeout after two beats
      do_req(4'd3);
      tick();
      chk("tmo_nn_start", 32'(bus.nn_start), 32'd1);
      bus.q_valid = 1'b1;
      bus.q_data  = 16'h0100;
      tick();
      bus.q_data  = 16'h0200;
      tick();
      bus.q_valid = 1'b0;
      chk("tmo_st_hold", 32'(bus.st), 32'd3);
      chk("tmo_early_valid", 32'(bus.act_valid), 32'd0);
      n = 0;
      while (!bus.act_valid && n < 400) begin
         tick();
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd255);
      chk("tmo_err", 32'(bus.err), 32'd1);
      chk("tmo_action", 32'(bus.action), 32'd0);
      chk("tmo_q_max", 32'(bus.q_max), 32'd0);
      chk("tmo_st", 32'(bus.st), 32'd0);
      do_ack();

      // backpressure with a pending request and stray beats
      do_req(4'd2);
      do_beats(4'd2, '{16'h0300, 16'h0500, 16'h0100, 16'h0200}, 2'd1, 16'h0500, "bp");
      bus.req_state = 4'd4;
      bus.req_valid = 1'b1;
      bus.q_valid   = 1'b1;
      bus.q_data    = 16'h7FFF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_act_valid", 32'(bus.act_valid), 32'd1);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         chk("bp_action", 32'(bus.action), 32'd1);
         chk("bp_q_max", 32'(bus.q_max), 32'h0500);
         chk("bp_st", 32'(bus.st), 32'd0);
      end
      bus.q_valid   = 1'b0;
      bus.act_ready = 1'b1;
      tick();
      bus.act_ready = 1'b0;
      chk("bp_rel_valid", 32'(bus.act_valid), 32'd0);
      chk("bp_rel_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      chk("b2b_st", 32'(bus.st), 32'd4);
      chk("b2b_ready", 32'(bus.req_ready), 32'd0);
      do_beats(4'd4, '{16'hF000, 16'hE000, 16'hF000, 16'hD000}, 2'd0, 16'hF000, "b2b");
      do_ack();

      // reset in WAIT after one beat
      do_req(4'd6);
      tick();
      bus.q_valid = 1'b1;
      bus.q_data  = 16'h0700;
      tick();
      bus.q_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_st", 32'(bus.st), 32'd0);
      chk("mrst_nn_start", 32'(bus.nn_start), 32'd0);
      chk("mrst_act_valid", 32'(bus.act_valid), 32'd0);
      chk("mrst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("mrst_err", 32'(bus.err), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      do_req(4'd7);
      do_beats(4'd7, '{16'h0200, 16'h0300, 16'h0100, 16'h0300}, 2'd1, 16'h0300, "post_rst");
      do_ack();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
